// File: rtl/riscv_pkg.sv
// Shared fetch definitions: FSM state encoding, NOP word, reset PC and PC step.
package riscv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/instr_fetch_pc.sv
// Program counter and next-PC select. A load takes redirect, then the pending
// target, then PC+4. A latch captures a redirect as pending without moving PC,
// so the address of an in-flight request stays stable.
module instr_fetch_pc
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redir_i,
  input  logic [XLEN-1:0] redir_pc_i,
  input  logic            latch_i,
  input  logic            load_i,
  input  logic            clr_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pend_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_q, pend_d;

  // next PC and pending target selection
  always_comb begin
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (clr_i) begin
      pend_d = 1'b0;
    end else if (load_i) begin
      if (redir_i) begin
        pc_d = redir_pc_i;
      end else if (pend_q) begin
        pc_d = pend_pc_q;
      end else begin
        pc_d = pc_q + XLEN'(PC_INC);
      end
      pend_d = 1'b0;
    end else if (latch_i && redir_i) begin
      pend_d    = 1'b1;
      pend_pc_d = redir_pc_i;
    end
  end

  // PC and pending registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= RESET_PC;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign pc_o   = pc_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: request/response handshake with instruction
// memory, holding the fetched word for the decoder, and redirect handling.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets trap into
// FAULT; without it the low two target bits are forced to zero.
//
// state | meaning
// IDLE  | one cycle after reset, then fetch starts
// REQ   | imem_req high at PC, waiting for grant
// WAIT  | granted, waiting for read data
// HOLD  | instruction presented to decoder
// FAULT | misaligned redirect seen, no fetching
module instr_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault
);

  fetch_state_e    state_q, state_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            pc_latch, pc_load, pc_clr;
  logic [XLEN-1:0] pc;
  logic            pend;
  logic            redir_ok, redir_bad;
  logic [XLEN-1:0] redir_pc_m;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_pc_m  = redirect_pc;
  assign redir_bad   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = (state_q == ST_FAULT);
`else
  logic unused_redir_lo;
  assign unused_redir_lo = ^redirect_pc[1:0];
  assign redir_pc_m  = {redirect_pc[XLEN-1:2], 2'b00};
  assign redir_bad   = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign redir_ok = redirect_valid && !redir_bad;

  instr_fetch_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i      (clk),
    .rst_ni     (rst),
    .redir_i    (redir_ok),
    .redir_pc_i (redir_pc_m),
    .latch_i    (pc_latch),
    .load_i     (pc_load),
    .clr_i      (pc_clr),
    .pc_o       (pc),
    .pend_o     (pend)
  );

  // next state, captured instruction and PC-update controls
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    pc_latch  = 1'b0;
    pc_load   = 1'b0;
    pc_clr    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        pc_load = redir_ok;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        pc_latch = 1'b1;
        if (imem_gnt) begin
          discard_d = pend | redir_ok;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        pc_latch = 1'b1;
        if (redir_ok) discard_d = 1'b1;
        if (imem_rvalid) begin
          if (redir_ok || discard_q) begin
            pc_load   = 1'b1;
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redir_ok || instr_ready) begin
          pc_load = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_FAULT: begin
        if (redir_ok) begin
          pc_load = 1'b1;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // a misaligned target overrides everything and parks the fetch unit
    if (redir_bad) begin
      pc_latch  = 1'b0;
      pc_load   = 1'b0;
      pc_clr    = 1'b1;
      discard_d = 1'b0;
      state_d   = ST_FAULT;
    end
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      discard_q <= 1'b0;
      instr_q   <= XLEN'(NOP_INSTR);
      ipc_q     <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state_q == ST_HOLD);
  assign instruction = instr_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: behavioural memory and decoder, expected request
// addresses and delivered PCs held in scoreboard queues.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  typedef struct {
    int          gnt_dly;
    int          rv_dly;
    int          ready_dly;
    logic [31:0] pc;
    bit          gap;
  } vec_t;

  vec_t        vecs[6];
  int          n_checks = 0, n_pass = 0;
  int          cyc = 0, hs_count = 0, grants = 0, last_hs_cyc = 0;
  int          gnt_dly = 0, rv_dly = 0, ready_dly = 0;
  int          req_cnt = 0, hold_cnt = 0, rv_wait = 0;
  bit          rv_out = 0, gap_chk = 0, chk_novalid = 0;
  logic [31:0] rv_addr = '0;
  bit          redir_wait_en = 0, redir_req_en = 0, redir_hs_en = 0, redir_hold_en = 0, redir_now_en = 0;
  logic [31:0] redir_wait_tgt, redir_req_tgt, redir_hs_tgt, redir_hold_tgt, redir_now_tgt;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] next_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive_redir(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
  endtask

  // one clock cycle: drive memory/decoder/redirect inputs from settled outputs,
  // compare against the scoreboard, then advance to just after the next edge
  task automatic tick();
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'hDEAD_BEEF;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (chk_novalid) begin
      chk("valid_drop_after_hold_redirect", 32'(instr_valid), 32'h0);
      chk_novalid = 0;
    end
`ifndef FETCH_MISALIGN_CHECK_EN
    chk("fetch_fault_tied", 32'(fetch_fault), 32'h0);
`endif
    if (redir_now_en) begin
      drive_redir(redir_now_tgt);
      redir_now_en = 0;
    end
    if (rv_out) begin
      if (rv_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(rv_addr);
        rv_out      = 0;
      end else begin
        rv_wait--;
      end
    end
    if (imem_req) begin
      if (exp_addr_q.size() == 0) chk("unexpected_imem_req", imem_addr, 32'hxxxx_xxxx);
      else chk("imem_addr", imem_addr, exp_addr_q[0]);
      if (req_cnt >= gnt_dly) begin
        imem_gnt = 1'b1;
        req_cnt  = 0;
        if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
        rv_out  = 1;
        rv_wait = rv_dly;
        rv_addr = imem_addr;
        grants++;
      end else begin
        req_cnt++;
        if (redir_req_en) begin
          drive_redir(redir_req_tgt);
          redir_req_en = 0;
        end
      end
    end
    if (rv_out && !imem_rvalid && !imem_gnt && redir_wait_en) begin
      drive_redir(redir_wait_tgt);
      redir_wait_en = 0;
    end
    if (instr_valid) begin
      if (exp_instr_q.size() == 0) begin
        chk("unexpected_instr_valid", instr_pc, 32'hxxxx_xxxx);
      end else begin
        chk("instr_pc", instr_pc, exp_instr_q[0]);
        chk("instruction", instruction, mem_word(exp_instr_q[0]));
      end
      if (redir_hold_en) begin
        drive_redir(redir_hold_tgt);
        redir_hold_en = 0;
        hold_cnt      = 0;
        chk_novalid   = 1;
        if (exp_instr_q.size() > 0) void'(exp_instr_q.pop_front());
      end else if (hold_cnt >= ready_dly) begin
        instr_ready = 1'b1;
        hold_cnt    = 0;
        if (exp_instr_q.size() > 0) void'(exp_instr_q.pop_front());
        if (gap_chk) chk("cycles_per_instr", 32'(cyc - last_hs_cyc), 32'd3);
        last_hs_cyc = cyc;
        hs_count++;
        if (redir_hs_en) begin
          drive_redir(redir_hs_tgt);
          redir_hs_en = 0;
        end
      end else begin
        hold_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_txn(input string name);
    int start;
    int budget;
    start    = hs_count;
    budget   = 0;
    hold_cnt = 0;
    while (hs_count == start && budget < 80) begin
      tick();
      budget++;
    end
    if (hs_count == start) begin
      n_checks++;
      $display("FAIL %s: no decoder handshake, got none within 80 cycles, required one", name);
    end
  endtask

  task automatic push(input logic [31:0] a, input bit deliver);
    exp_addr_q.push_back(a);
    if (deliver) exp_instr_q.push_back(a);
  endtask

  task automatic chk_reset_values();
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instruction", instruction, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_fetch_fault", 32'(fetch_fault), 32'h0);
  endtask

  initial begin
    // gnt_dly, rv_dly, ready_dly, pc, check 3-cycle spacing
    vecs[0] = '{0, 0, 0, 32'h00, 1'b0};
    vecs[1] = '{0, 0, 0, 32'h04, 1'b1};
    vecs[2] = '{0, 0, 0, 32'h08, 1'b1};
    vecs[3] = '{2, 0, 0, 32'h0C, 1'b0};
    vecs[4] = '{0, 1, 5, 32'h10, 1'b0};
    vecs[5] = '{1, 2, 2, 32'h14, 1'b0};

    rst = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values();
    rst = 1'b1;

    // straight-line fetch, stalls on grant/data/ready
    for (int i = 0; i < 6; i++) begin
      gnt_dly   = vecs[i].gnt_dly;
      rv_dly    = vecs[i].rv_dly;
      ready_dly = vecs[i].ready_dly;
      gap_chk   = vecs[i].gap;
      push(vecs[i].pc, 1'b1);
      run_txn($sformatf("vec%0d", i));
    end
    gap_chk = 0;

    // redirect while waiting for data: 0x18 is dropped, 0x100 fetched
    gnt_dly = 0; rv_dly = 2; ready_dly = 0;
    push(32'h18, 1'b0);
    push(32'h100, 1'b1);
    redir_wait_en = 1; redir_wait_tgt = 32'h100;
    run_txn("redirect_in_wait");

    // redirect in REQ with grant delayed 3 cycles: 0x104 held, then 0x300
    gnt_dly = 3; rv_dly = 0;
    push(32'h104, 1'b0);
    push(32'h300, 1'b1);
    redir_req_en = 1; redir_req_tgt = 32'h300;
    run_txn("redirect_in_req");

    // ready and redirect in the same HOLD cycle
    gnt_dly = 0;
    push(32'h304, 1'b1);
    redir_hs_en = 1; redir_hs_tgt = 32'h400;
    run_txn("ready_with_redirect");
    push(32'h400, 1'b1);
    redir_hs_en = 1; redir_hs_tgt = 32'hFFFF_FFFC;
    run_txn("redirect_to_top");

    // PC+4 wraps from the top of the address space
    push(32'hFFFF_FFFC, 1'b1);
    run_txn("top_of_space");

    // redirect in HOLD while not ready: valid drops, 0x500 fetched
    ready_dly = 3;
    push(32'h0, 1'b1);
    push(32'h500, 1'b1);
    redir_hold_en = 1; redir_hold_tgt = 32'h500;
    redir_hs_en = 1;
`ifdef FETCH_MISALIGN_CHECK_EN
    redir_hs_tgt = 32'h102;
`else
    redir_hs_tgt = 32'h603;
`endif
    run_txn("redirect_in_hold");
    ready_dly = 0;

`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      chk("fault_set", 32'(fetch_fault), 32'h1);
      chk("fault_no_req", 32'(imem_req), 32'h0);
      tick();
    end
    redir_now_en = 1; redir_now_tgt = 32'h200;
    push(32'h200, 1'b1);
    run_txn("fault_exit");
    chk("fault_cleared", 32'(fetch_fault), 32'h0);
    next_pc = 32'h204;
`else
    push(32'h600, 1'b1);
    run_txn("misaligned_forced");
    next_pc = 32'h604;
`endif

    // reset in the middle of a transaction; the late rvalid must be ignored
    begin
      int g0;
      int budget;
      g0 = grants;
      budget = 0;
      rv_dly = 3;
      push(next_pc, 1'b1);
      while (grants == g0 && budget < 20) begin
        tick();
        budget++;
      end
      if (grants == g0) begin
        n_checks++;
        $display("FAIL mid_reset_grant: got no grant within 20 cycles, required one");
      end
      rst = 1'b0;
      tick();
      tick();
      chk_reset_values();
      exp_addr_q.delete();
      exp_instr_q.delete();
      rst = 1'b1;
      rv_dly = 0;
      push(32'h0, 1'b1);
      run_txn("after_mid_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
